// File: rtl/nco_bank_if.sv
// nco_bank_if: register-write, sine ROM and mix output bundle of the NCO bank
interface nco_bank_if #(
  parameter int VOICES = 8,
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 12,
  parameter int DATA_W = 16
);
  localparam int VW = $clog2(VOICES);
  logic sample_tick;
  logic wr_en;
  logic [VW-1:0] wr_voice;
  logic [1:0] wr_sel;
  logic [PHASE_W-1:0] wr_data;
  logic [LUT_AW-1:0] rom_addr;
  logic signed [DATA_W-1:0] rom_data;
  logic signed [DATA_W+VW-1:0] mix_out;
  logic mix_valid;
  logic busy;
  logic overrun;
  modport master (
    output sample_tick, wr_en, wr_voice, wr_sel, wr_data, rom_data,
    input rom_addr, mix_out, mix_valid, busy, overrun
  );
  modport slave (
    input sample_tick, wr_en, wr_voice, wr_sel, wr_data, rom_data,
    output rom_addr, mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/nco_bank.sv
// nco_bank: time-multiplexed bank of NCOs sharing one sine ROM and one multiplier, summed per sample_tick
module nco_bank #(
  parameter int VOICES = 8,
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 12,
  parameter int DATA_W = 16,
  parameter int AMP_W = 16
) (
  input logic Clk,
  input logic Reset_n,
  nco_bank_if.slave bus
);
  localparam int VW = $clog2(VOICES);
  localparam int MW = DATA_W + VW;
  localparam int PW = DATA_W + AMP_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_st, w_nst;
  logic [PHASE_W-1:0] r_freq [VOICES];
  logic [PHASE_W-1:0] r_phase [VOICES];
  logic [AMP_W-1:0] r_amp [VOICES];
  logic [1:0] r_wave [VOICES];
  logic [VW-1:0] r_v;
  logic r_vld1, r_vld2, r_vld3, r_last1, r_last2, r_last3;
  logic [DATA_W:0] r_p1;
  logic [1:0] r_wv1;
  logic [AMP_W-1:0] r_amp1, r_amp2;
  logic signed [DATA_W-1:0] r_w2, r_sc3, w_wave, w_sc;
  logic [DATA_W-1:0] w_tri;
  logic signed [PW-1:0] w_prod;
  logic signed [MW-1:0] r_acc, r_mix;
  logic r_mix_vld, r_ovr, w_run, w_start;
  assign w_run = r_st == RUN;
  assign w_start = r_st == IDLE && bus.sample_tick;
  assign bus.busy = r_st != IDLE;
  assign bus.rom_addr = w_run ? r_phase[r_v][PHASE_W-1 -: LUT_AW] : '0;
  assign bus.mix_out = r_mix;
  assign bus.mix_valid = r_mix_vld;
  assign bus.overrun = r_ovr;
  always_comb begin
    w_nst = w_start ? RUN :
            w_run && r_v == VW'(VOICES-1) ? DRAIN :
            r_st == DRAIN && r_vld3 && r_last3 ? IDLE : r_st;
  end
  // r_p1 holds the phase MSB plus the DATA_W bits below it, enough for every waveform
  assign w_tri = r_p1[DATA_W] ? ~r_p1[DATA_W-1:0] : r_p1[DATA_W-1:0];
  assign w_wave = r_wv1 == 2'd0 ? bus.rom_data :
                  r_wv1 == 2'd1 ? {~r_p1[DATA_W], r_p1[DATA_W-1:1]} :
                  r_wv1 == 2'd2 ? (r_p1[DATA_W] ? {1'b1, {(DATA_W-2){1'b0}}, 1'b1} : {1'b0, {(DATA_W-1){1'b1}}}) :
                  {~w_tri[DATA_W-1], w_tri[DATA_W-2:0]};
  assign w_prod = PW'(r_w2) * $signed({{(PW-AMP_W){1'b0}}, r_amp2});
  assign w_sc = DATA_W'(w_prod >>> AMP_W);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < VOICES; i++) begin
        r_freq[i] <= '0;
        r_phase[i] <= '0;
        r_amp[i] <= '0;
        r_wave[i] <= '0;
      end
    end else begin
      if (w_run) r_phase[r_v] <= r_phase[r_v] + r_freq[r_v];
      if (bus.wr_en && bus.wr_sel == 2'd0) r_freq[bus.wr_voice] <= bus.wr_data;
      if (bus.wr_en && bus.wr_sel == 2'd1) r_amp[bus.wr_voice] <= bus.wr_data[AMP_W-1:0];
      if (bus.wr_en && bus.wr_sel == 2'd2) r_wave[bus.wr_voice] <= bus.wr_data[1:0];
      if (bus.wr_en && bus.wr_sel == 2'd3) r_phase[bus.wr_voice] <= bus.wr_data;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_st <= IDLE;
      r_v <= '0;
      {r_vld1, r_vld2, r_vld3, r_last1, r_last2, r_last3} <= '0;
      r_p1 <= '0;
      r_wv1 <= '0;
      r_amp1 <= '0;
      r_amp2 <= '0;
      r_w2 <= '0;
      r_sc3 <= '0;
      r_acc <= '0;
      r_mix <= '0;
      r_mix_vld <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_st <= w_nst;
      r_v <= w_run ? r_v + 1'b1 : '0;
      r_vld1 <= w_run;
      r_last1 <= w_run && r_v == VW'(VOICES-1);
      r_p1 <= r_phase[r_v][PHASE_W-1 -: DATA_W+1];
      r_wv1 <= r_wave[r_v];
      r_amp1 <= r_amp[r_v];
      r_vld2 <= r_vld1;
      r_last2 <= r_last1;
      r_w2 <= w_wave;
      r_amp2 <= r_amp1;
      r_vld3 <= r_vld2;
      r_last3 <= r_last2;
      r_sc3 <= w_sc;
      r_mix_vld <= r_vld3 && r_last3;
      if (w_start) r_acc <= '0;
      else if (r_vld3) r_acc <= r_acc + MW'(r_sc3);
      // the last voice folds straight into the output so mix_valid lands with the final sum
      if (r_vld3 && r_last3) r_mix <= r_acc + MW'(r_sc3);
      if (bus.sample_tick && bus.busy) r_ovr <= 1'b1;
    end
  end
endmodule
